mem_stage: RTL

//   Memory-access stage of the 5-stage MIPS pipeline, between exe_stage and wb_stage. Receives EXE's result bus

---
 rtl/mem_stage.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS pipeline memory-access stage: load response wait, alignment, WB handoff, flush discard
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 128,
    parameter int MS_TO_WS_BUS_WD = 124,
    parameter int MS_FWD_BUS_WD   = 39
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic                       es_to_ms_req,
    input  logic                       es_req_cancel,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus,
    output logic                       ms_ex,
    input  logic                       flush
);

    logic                       ms_valid;
    logic                       wait_data;
    logic                       buf_valid;
    logic [31:0]                rdata_buf;
    logic [1:0]                 discard_cnt;
    logic [ES_TO_MS_BUS_WD-1:0] es_bus_r;

    logic [31:0] ms_badvaddr;
    logic [10:0] ms_c0_bus;
    logic        ms_bd;
    logic        ms_ex_flag;
    logic [4:0]  ms_excode;
    logic [6:0]  ms_ld_inst;
    logic        ms_res_from_mem;
    logic        ms_gr_we;
    logic [4:0]  ms_dest;
    logic [31:0] ms_res;
    logic [31:0] ms_pc;

    assign {ms_badvaddr, ms_c0_bus, ms_bd, ms_ex_flag, ms_excode, ms_ld_inst,
            ms_res_from_mem, ms_gr_we, ms_dest, ms_res, ms_pc} = es_bus_r;

    logic ld_lw, ld_lb, ld_lbu, ld_lh, ld_lhu, ld_lwl, ld_lwr;
    assign {ld_lw, ld_lb, ld_lbu, ld_lh, ld_lhu, ld_lwl, ld_lwr} = ms_ld_inst;

    // A response is ours only once all responses of killed requests have drained.
    logic data_ok_ours;
    logic ms_ready_go;
    assign data_ok_ours   = data_sram_data_ok && (discard_cnt == 2'd0);
    assign ms_ready_go    = !wait_data || data_ok_ours;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go && !flush;
    assign ms_ex          = ms_valid && ms_ex_flag;

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid  <= 1'b0;
            wait_data <= 1'b0;
            buf_valid <= 1'b0;
        end else if (flush) begin
            ms_valid  <= 1'b0;
            wait_data <= 1'b0;
            buf_valid <= 1'b0;
        end else begin
            if (ms_allowin) begin
                ms_valid  <= es_to_ms_valid;
                wait_data <= es_to_ms_valid && es_to_ms_req && !es_to_ms_bus[83];
                buf_valid <= 1'b0;
            end else if (data_ok_ours && wait_data) begin
                wait_data <= 1'b0;
                if (!ws_allowin) begin
                    buf_valid <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!flush && ms_allowin && es_to_ms_valid) begin
            es_bus_r <= es_to_ms_bus;
        end
        if (data_ok_ours && wait_data && !ws_allowin) begin
            rdata_buf <= data_sram_rdata;
        end
    end

    logic [1:0] discard_inc;
    logic [1:0] discard_dec;
    assign discard_inc = {1'b0, flush && wait_data && !data_ok_ours} + {1'b0, es_req_cancel};
    assign discard_dec = {1'b0, data_sram_data_ok && (discard_cnt != 2'd0)};

    always_ff @(posedge clk) begin
        if (reset) begin
            discard_cnt <= 2'd0;
        end else begin
            discard_cnt <= discard_cnt + discard_inc - discard_dec;
        end
    end

    logic [31:0] ld_data;
    logic [1:0]  addr_lo;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_result;
    logic [3:0]  load_strb;

    assign ld_data = buf_valid ? rdata_buf : data_sram_rdata;
    assign addr_lo = ms_res[1:0];
    assign ld_half = addr_lo[1] ? ld_data[31:16] : ld_data[15:0];

    always_comb begin
        ld_byte = ld_data[7:0];
        case (addr_lo)
            2'd0: ld_byte = ld_data[7:0];
            2'd1: ld_byte = ld_data[15:8];
            2'd2: ld_byte = ld_data[23:16];
            2'd3: ld_byte = ld_data[31:24];
            default: ld_byte = ld_data[7:0];
        endcase
    end

    always_comb begin
        load_result = ld_data;
        load_strb   = 4'hf;
        if (ld_lb) begin
            load_result = {{24{ld_byte[7]}}, ld_byte};
        end else if (ld_lbu) begin
            load_result = {24'b0, ld_byte};
        end else if (ld_lh) begin
            load_result = {{16{ld_half[15]}}, ld_half};
        end else if (ld_lhu) begin
            load_result = {16'b0, ld_half};
        end else if (ld_lwl) begin
            case (addr_lo)
                2'd0: begin load_result = {ld_data[7:0], 24'b0};  load_strb = 4'b1000; end
                2'd1: begin load_result = {ld_data[15:0], 16'b0}; load_strb = 4'b1100; end
                2'd2: begin load_result = {ld_data[23:0], 8'b0};  load_strb = 4'b1110; end
                default: begin load_result = ld_data;            load_strb = 4'b1111; end
            endcase
        end else if (ld_lwr) begin
            case (addr_lo)
                2'd0: begin load_result = ld_data;                 load_strb = 4'b1111; end
                2'd1: begin load_result = {8'b0, ld_data[31:8]};   load_strb = 4'b0111; end
                2'd2: begin load_result = {16'b0, ld_data[31:16]}; load_strb = 4'b0011; end
                default: begin load_result = {24'b0, ld_data[31:24]}; load_strb = 4'b0001; end
            endcase
        end else if (ld_lw) begin
            load_result = ld_data;
        end
    end

    logic [31:0] final_result;
    logic [3:0]  rf_wstrb;
    assign final_result = ms_res_from_mem ? load_result : ms_res;
    assign rf_wstrb     = (ms_gr_we && !ms_ex_flag) ? (ms_res_from_mem ? load_strb : 4'hf) : 4'h0;

    assign ms_to_ws_bus = {ms_badvaddr, ms_c0_bus, ms_bd, ms_ex_flag, ms_excode,
                           rf_wstrb, ms_gr_we, ms_dest, final_result, ms_pc};

    logic ms_load_busy;
    logic ms_block_valid;
    assign ms_load_busy   = ms_valid && ms_res_from_mem && !ms_ready_go;
    assign ms_block_valid = ms_valid && ms_gr_we && !flush;
    assign ms_fwd_bus     = {ms_load_busy, ms_block_valid, ms_dest, final_result};

endmodule
